// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: bus commands, tag sizing,
// the delay-line entry layout and the tag rotation helper.
package dmem_responder_pkg;

  localparam int unsigned MEM_TAG_W   = 4;
  localparam int unsigned MEM_MAX_TAG = 15;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_t;

  // One in-flight request as it travels down the completion delay line.
  typedef struct packed {
    logic                 valid;
    logic [MEM_TAG_W-1:0] tag;
    logic [31:0]          data;
  } resp_entry_t;

  // Tags rotate 1..MEM_MAX_TAG; 0 is reserved for "no request".
  function automatic logic [MEM_TAG_W-1:0] next_tag_after(input logic [MEM_TAG_W-1:0] t);
    return (t == MEM_TAG_W'(MEM_MAX_TAG)) ? MEM_TAG_W'(1) : t + MEM_TAG_W'(1);
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency completion delay line. Stage 0 is loaded on the accept edge; the
// last stage is the registered bus output, so a request shows up LATENCY cycles
// after it was accepted.
module mem_resp_pipe #(
  parameter int unsigned LATENCY = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  in_tag,
  input  logic [31:0] in_data,
  output logic [3:0]  out_tag,
  output logic [31:0] out_data,
  output logic        retire
);
  import dmem_responder_pkg::*;

  resp_entry_t [LATENCY-1:0] stage_q;
  resp_entry_t [LATENCY-1:0] stage_d;

  // Shift every entry one stage towards the output, inserting the new request.
  always_comb begin
    stage_d[0].valid = in_valid;
    stage_d[0].tag   = in_tag;
    stage_d[0].data  = in_data;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Delay-line registers; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // An entry stops counting as outstanding on the edge it enters the output stage.
  always_comb begin
    retire   = stage_d[LATENCY-1].valid;
    out_tag  = stage_q[LATENCY-1].valid ? stage_q[LATENCY-1].tag : 4'd0;
    out_data = stage_q[LATENCY-1].valid ? stage_q[LATENCY-1].data : 32'd0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the proc2Dmem/mem2proc bus: word array, same-cycle accept
// with tag allocation, in-flight limit, and fixed-latency completions.
module dmem_responder #(
  parameter int unsigned MEM_WORDS       = 16384,
  parameter int unsigned LATENCY         = 10,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  proc2mem_command,
  input  logic [31:0] proc2mem_addr,
  input  logic [31:0] proc2mem_data,
  output logic [3:0]  mem2proc_response,
  output logic [31:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);
  import dmem_responder_pkg::*;

  localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0]     mem [MEM_WORDS];
  logic [3:0]      next_tag_q;
  logic [3:0]      outstanding_q;
  logic [3:0]      outstanding_d;
  logic            is_load;
  logic            is_store;
  logic            in_range;
  logic            accept;
  logic            retire;
  logic [IdxW-1:0] idx;
  logic [31:0]     load_data;

  // Accept decision and the load snapshot taken at the accept edge.
  always_comb begin
    is_load   = (proc2mem_command == 2'(BUS_LOAD));
    is_store  = (proc2mem_command == 2'(BUS_STORE));
    in_range  = (proc2mem_addr[31:2] < 30'(MEM_WORDS));
    idx       = proc2mem_addr[IdxW+1:2];
    accept    = (is_load || is_store) && (proc2mem_addr[1:0] == 2'b00) && in_range &&
                (outstanding_q < 4'(MAX_OUTSTANDING)) && !rst;
    mem2proc_response = accept ? next_tag_q : 4'd0;
    load_data = (accept && is_load) ? mem[idx] : 32'd0;
  end

  // Backing array: written only by accepted stores, never reset.
  always_ff @(posedge clk) begin
    if (accept && is_store) begin
      mem[idx] <= proc2mem_data;
    end
  end

  // Slot accounting: accept and retire on the same edge cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({accept, retire})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Tag rotation and outstanding counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_tag_q    <= 4'd1;
      outstanding_q <= 4'd0;
    end else begin
      if (accept) begin
        next_tag_q <= next_tag_after(next_tag_q);
      end
      outstanding_q <= outstanding_d;
    end
  end

  mem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .in_tag   (mem2proc_response),
    .in_data  (load_data),
    .out_tag  (mem2proc_tag),
    .out_data (mem2proc_data),
    .retire   (retire)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table-driven directed sequences plus randomized
// traffic, all checked against a transaction-level model (a queue of in-flight
// requests stamped with their accept cycle and a sparse word memory).
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int MEM_WORDS = 16384;
  localparam int LAT       = 10;
  localparam int MAX_OUT   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cmd = 2'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  resp;
  logic [3:0]  tag;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  dmem_responder #(
    .MEM_WORDS       (MEM_WORDS),
    .LATENCY         (LAT),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .proc2mem_command  (cmd),
    .proc2mem_addr     (addr),
    .proc2mem_data     (wdata),
    .mem2proc_response (resp),
    .mem2proc_data     (rdata),
    .mem2proc_tag      (tag)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  typedef struct {
    int          k;
    logic [3:0]  tag;
    logic [31:0] data;
    bit          known;
  } fl_t;
  fl_t         fq[$];
  bit [31:0]   mm[int];
  int          nt  = 1;
  int          cyc = 0;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_resp;
    logic [3:0]  exp_tag;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got 0x%08h required 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle, check the DUT against the model, advance the model.
  task automatic do_cycle(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                          input logic r, output logic [3:0] s_resp, output logic [3:0] s_tag,
                          output logic [31:0] s_data);
    logic [3:0]  e_resp;
    logic [3:0]  e_tag;
    logic [31:0] e_data;
    logic [31:0] word;
    bit          known;
    bit          acc;
    int          outst;
    fl_t         e;
    rst = r; cmd = c; addr = a; wdata = d;
    @(negedge clk);
    s_resp = resp; s_tag = tag; s_data = rdata;
    e_resp = 4'd0; e_tag = 4'd0; e_data = 32'd0; known = 1'b1; acc = 1'b0;
    word = a >> 2;
    if (r) begin
      fq.delete();
      nt = 1;
    end else begin
      outst = 0;
      foreach (fq[i]) begin
        if (fq[i].k + LAT == cyc) begin
          e_tag = fq[i].tag; e_data = fq[i].data; known = fq[i].known;
        end
        if (fq[i].k + LAT > cyc) outst++;
      end
      acc = ((c == BUS_LOAD) || (c == BUS_STORE)) && (a[1:0] == 2'b00) &&
            (word < 32'(MEM_WORDS)) && (outst < MAX_OUT);
      if (acc) e_resp = 4'(nt);
    end
    check("response", 32'(s_resp), 32'(e_resp));
    check("tag", 32'(s_tag), 32'(e_tag));
    if (known) check("data", s_data, e_data);
    if (acc) begin
      e.k = cyc; e.tag = 4'(nt); e.data = 32'd0; e.known = 1'b1;
      if (c == BUS_STORE) begin
        mm[int'(word)] = d;
      end else if (mm.exists(int'(word))) begin
        e.data = mm[int'(word)];
      end else begin
        e.known = 1'b0;
      end
      fq.push_back(e);
      nt = (nt == 15) ? 1 : nt + 1;
    end
    while (fq.size() > 0 && fq[0].k + LAT <= cyc) void'(fq.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic add(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] er, input logic [3:0] et, input logic [31:0] ed);
    vec_t v;
    v.cmd = c; v.addr = a; v.wdata = d; v.exp_resp = er; v.exp_tag = et; v.exp_data = ed;
    vq.push_back(v);
  endtask

  task automatic run_table(input string label);
    logic [3:0]  r;
    logic [3:0]  t;
    logic [31:0] dd;
    foreach (vq[i]) begin
      do_cycle(vq[i].cmd, vq[i].addr, vq[i].wdata, 1'b0, r, t, dd);
      check($sformatf("%s[%0d] resp", label, i), 32'(r), 32'(vq[i].exp_resp));
      check($sformatf("%s[%0d] tag", label, i), 32'(t), 32'(vq[i].exp_tag));
      check($sformatf("%s[%0d] data", label, i), dd, vq[i].exp_data);
    end
    vq.delete();
  endtask

  task automatic do_reset();
    logic [3:0]  r;
    logic [3:0]  t;
    logic [31:0] dd;
    do_cycle(BUS_NONE, 32'd0, 32'd0, 1'b1, r, t, dd);
    do_cycle(BUS_NONE, 32'd0, 32'd0, 1'b1, r, t, dd);
  endtask

  task automatic idle(input int n);
    logic [3:0]  r;
    logic [3:0]  t;
    logic [31:0] dd;
    for (int i = 0; i < n; i++) do_cycle(BUS_NONE, 32'd0, 32'd0, 1'b0, r, t, dd);
  endtask

  initial begin
    logic [3:0]  r;
    logic [3:0]  t;
    logic [31:0] dd;
    logic [31:0] a;
    logic [3:0]  c;
    int          sel;

    do_reset();
    check("reset tag", 32'(tag), 32'd0);
    check("reset data", rdata, 32'd0);

    // Store then load, completions at +10 and +11.
    add(BUS_STORE, 32'h100, 32'hDEADBEEF, 4'd1, 4'd0, 32'd0);
    add(BUS_LOAD,  32'h100, 32'd0,        4'd2, 4'd0, 32'd0);
    for (int i = 2; i < 10; i++) add(BUS_NONE, 32'd0, 32'd0, 4'd0, 4'd0, 32'd0);
    add(BUS_NONE, 32'd0, 32'd0, 4'd0, 4'd1, 32'd0);
    add(BUS_NONE, 32'd0, 32'd0, 4'd0, 4'd2, 32'hDEADBEEF);
    add(BUS_NONE, 32'd0, 32'd0, 4'd0, 4'd0, 32'd0);
    run_table("t1");

    // Back-to-back loads hitting the in-flight limit.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      c = (i < 8) ? 4'(i + 1) : (i == 10) ? 4'd9 : (i == 11) ? 4'd10 : 4'd0;
      add(BUS_LOAD, 32'h100, 32'd0, c, (i == 10) ? 4'd1 : (i == 11) ? 4'd2 : 4'd0,
          (i >= 10) ? 32'hDEADBEEF : 32'd0);
    end
    run_table("t2");
    idle(14);

    // Illegal / out-of-range requests; out-of-range store must not alias word 0.
    do_reset();
    add(BUS_STORE, 32'h0,     32'hA5A5A5A5, 4'd1, 4'd0, 32'd0);
    add(BUS_LOAD,  32'h102,   32'd0,        4'd0, 4'd0, 32'd0);
    add(BUS_LOAD,  32'h10000, 32'd0,        4'd0, 4'd0, 32'd0);
    add(BUS_STORE, 32'h10000, 32'h12345678, 4'd0, 4'd0, 32'd0);
    add(2'd3,      32'h0,     32'd0,        4'd0, 4'd0, 32'd0);
    add(BUS_LOAD,  32'h0,     32'd0,        4'd2, 4'd0, 32'd0);
    for (int i = 6; i < 17; i++)
      add(BUS_NONE, 32'd0, 32'd0, 4'd0, (i == 10) ? 4'd1 : (i == 15) ? 4'd2 : 4'd0,
          (i == 15) ? 32'hA5A5A5A5 : 32'd0);
    run_table("t3");

    // Tag rotation across the 15->1 wrap.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      do_cycle(BUS_LOAD, 32'h100, 32'd0, 1'b0, r, t, dd);
      check($sformatf("t4 tag seq %0d", i), 32'(r), 32'((i % 15) + 1));
      do_cycle(BUS_NONE, 32'd0, 32'd0, 1'b0, r, t, dd);
    end
    idle(12);

    // Load snapshot is not disturbed by a later store.
    do_reset();
    do_cycle(BUS_STORE, 32'h40, 32'd5, 1'b0, r, t, dd);
    do_cycle(BUS_LOAD,  32'h40, 32'd0, 1'b0, r, t, dd);
    do_cycle(BUS_STORE, 32'h40, 32'd9, 1'b0, r, t, dd);
    do_cycle(BUS_LOAD,  32'h40, 32'd0, 1'b0, r, t, dd);
    for (int i = 4; i < 16; i++) begin
      do_cycle(BUS_NONE, 32'd0, 32'd0, 1'b0, r, t, dd);
      if (i == 11) check("t5 early load data", dd, 32'd5);
      if (i == 13) check("t5 late load data", dd, 32'd9);
    end

    // Reset mid-flight: nothing stale comes out, tags restart, array retained.
    do_reset();
    for (int i = 0; i < 4; i++) do_cycle(BUS_LOAD, 32'h40, 32'd0, 1'b0, r, t, dd);
    idle(2);
    do_cycle(BUS_LOAD, 32'h40, 32'd0, 1'b1, r, t, dd);
    check("t6 resp in reset", 32'(r), 32'd0);
    do_cycle(BUS_NONE, 32'd0, 32'd0, 1'b1, r, t, dd);
    do_cycle(BUS_LOAD, 32'h40, 32'd0, 1'b0, r, t, dd);
    check("t6 first tag after reset", 32'(r), 32'd1);
    for (int i = 1; i < 14; i++) begin
      do_cycle(BUS_NONE, 32'd0, 32'd0, 1'b0, r, t, dd);
      if (i == 10) check("t6 retained data", dd, 32'd9);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_cycle(BUS_STORE, 32'h200 + 32'(4 * i), $urandom, 1'b0, r, t, dd);
      idle(1);
    end
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = 32'h200 + 32'(4 * $urandom_range(0, 7));
      else if (sel == 7) a = 32'h201 + 32'(4 * $urandom_range(0, 7));
      else if (sel == 8) a = 32'(MEM_WORDS * 4) + 32'h200 + 32'(4 * $urandom_range(0, 7));
      else               a = 32'hFFFF_FFFC;
      do_cycle(2'($urandom_range(0, 3)), a, $urandom, ($urandom_range(0, 99) == 0), r, t, dd);
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
